// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter/sequencer in front of the system bridge (IDLE -> ADDR x (W+1) -> DATA).
// Optional address-window error reporting is enabled by defining ARB_ERR_EN.
module bus_arbiter #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic [31:0] m1_rd,
`ifdef ARB_ERR_EN
    output logic        m0_err,
    output logic        m1_err,
`endif
    output logic [31:0] PrAddr,
    output logic [31:0] PrWD,
    output logic        PrWE,
    input  logic [31:0] PrRD,
    output logic        busy,
    output logic        owner
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wd;
    logic             r_we;
    logic             r_first;
    logic             r_miss;
    logic [31:0]      r_rd_lat;
    logic             r_owner;

    logic [1:0]       w_req;
    logic             w_grant_any;
    logic             w_grant_sel;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wd;
    logic             w_sel_we;
    logic             w_miss;
    logic [1:0]       w_ack;
    logic [31:0]      w_rd [2];

    assign w_req       = {m1_req, m0_req};
    assign w_grant_any = |w_req;
    // On a tie the master that did not own the bus last time wins.
    assign w_grant_sel = (w_req == 2'b11) ? ~r_owner : w_req[1];
    assign w_sel_addr  = w_grant_sel ? m1_addr : m0_addr;
    assign w_sel_wd    = w_grant_sel ? m1_wd   : m0_wd;
    assign w_sel_we    = w_grant_sel ? m1_we   : m0_we;

`ifdef ARB_ERR_EN
    function automatic logic addr_mapped(input logic [31:0] a);
        logic hit;
        hit = 1'b0;
        if (a <= 32'h0000_2FFF)                        hit = 1'b1;
        if (a >= 32'h0000_7F00 && a <= 32'h0000_7F0B) hit = 1'b1;
        if (a >= 32'h0000_7F20 && a <= 32'h0000_7F3B) hit = 1'b1;
        if (a >= 32'h0000_7F40 && a <= 32'h0000_7F47) hit = 1'b1;
        if (a >= 32'h0000_7F50 && a <= 32'h0000_7F5B) hit = 1'b1;
        if (a >= 32'h0000_7F60 && a <= 32'h0000_7F63) hit = 1'b1;
        return hit;
    endfunction

    assign w_miss = ~addr_mapped(w_sel_addr);
`else
    assign w_miss = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wd     <= '0;
            r_we     <= 1'b0;
            r_first  <= 1'b0;
            r_miss   <= 1'b0;
            r_rd_lat <= '0;
            r_owner  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_addr  <= w_sel_addr;
                        r_wd    <= w_sel_wd;
                        r_we    <= w_sel_we;
                        r_miss  <= w_miss;
                        r_owner <= w_grant_sel;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        r_first <= 1'b1;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_first <= 1'b0;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rd_lat <= r_miss ? 32'h0 : PrRD;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus outputs are decoded from registered state so an asynchronous reset clears them at once.
    assign PrAddr = (r_state == ST_ADDR) ? r_addr : 32'h0;
    assign PrWD   = (r_state == ST_ADDR) ? r_wd   : 32'h0;
    assign PrWE   = (r_state == ST_ADDR) && r_first && r_we && !r_miss;
    assign busy   = (r_state != ST_IDLE);
    assign owner  = r_owner;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            localparam logic LP_ID = 1'(gi);
            assign w_ack[gi] = (r_state == ST_DATA) && (r_owner == LP_ID);
            assign w_rd[gi]  = w_ack[gi] ? r_rd_lat : 32'h0;
        end
    endgenerate

    assign m0_ack = w_ack[0];
    assign m1_ack = w_ack[1];
    assign m0_rd  = w_rd[0];
    assign m1_rd  = w_rd[1];

`ifdef ARB_ERR_EN
    assign m0_err = w_ack[0] && r_miss;
    assign m1_err = w_ack[1] && r_miss;
`endif

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the system bridge.
- Shares the single Pr* bus between the CPU data port (m0) and a secondary requester such as a DMA or debug loader (m1).
- Round-robin arbitration; every access runs as a fixed multi-cycle transaction, so slow devices get a programmable number of wait cycles before read data is sampled.
- Sits between the CPU/DMA and the bridge; the bridge decode is unchanged.

Parameters:
- WAIT_CYCLES, 0, extra ADDR-phase cycles before PrRD is sampled (0..15).
- CNT_W, 4, width of the wait counter; must hold WAIT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  CPU access request; held until m0_ack.
- m0_we  in  1  CPU write enable; valid with m0_req.
- m0_addr  in  32  CPU byte address.
- m0_wd  in  32  CPU write data.
- m0_ack  out  1  one-cycle completion pulse to CPU.
- m0_rd  out  32  CPU read data; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wd, m1_ack, m1_rd: same as m0, for master 1.
- PrAddr  out  32  bus address to bridge.
- PrWD  out  32  bus write data to bridge.
- PrWE  out  1  bus write enable to bridge.
- PrRD  in  32  bus read data from bridge.
- busy  out  1  transaction in flight (state != IDLE).
- owner  out  1  current or last granted master (0=m0, 1=m1).

Behaviour:
- Single clock domain, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, PrAddr=0, PrWD=0, PrWE=0, m0_ack=m1_ack=0, m0_rd=m1_rd=0, busy=0, owner=1. owner=1 means m0 wins the first tie.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - No req: stay. Pr* outputs are 0.
  - One req: grant that master.
  - Both req: grant !owner (round-robin).
  - On grant: latch that master's addr/wd/we, set owner, load cnt=WAIT_CYCLES, go to ADDR.
- ADDR:
  - PrAddr/PrWD come from the latched registers.
  - PrWE = latched_we only in the first ADDR cycle, so a device never sees a write twice.
  - If cnt!=0: decrement and stay. If cnt==0: capture PrRD into rd_lat at the clock edge and go to DATA.
  - ADDR lasts WAIT_CYCLES+1 cycles.
- DATA:
  - Pr* outputs return to 0.
  - Winner's ack=1 and rd=rd_lat, for exactly one cycle. The non-winner's ack=0 and rd=0.
  - Next state is always IDLE.
- Latency: request seen in IDLE → ack WAIT_CYCLES+3 cycles later (IDLE, ADDR×(W+1), DATA). Throughput is one access per W+3 cycles.
- Requester rules:
  - A master must hold req, addr, we and wd stable until it sees ack, and deassert req in the cycle after ack if it has no further access.
  - Request inputs are sampled only in IDLE; changes during ADDR/DATA are ignored.
  - Write transactions also return rd_lat (whatever PrRD was at sampling). Masters ignore it.
- Simultaneous events:
  - Both masters requesting continuously alternate m0, m1, m0, …
  - A single master requesting continuously is granted back-to-back with no fairness stall.
- Reset mid-transaction: immediate return to IDLE and all outputs to reset values. A pending write whose first ADDR cycle has not completed is not issued. Masters must re-request.
- Address passes through unmodified, including unaligned low bits; the bridge does its own decode.

Optional Feature:
- Macro: ARB_ERR_EN.
- Defined:
  - Adds output ports m0_err and m1_err (1 bit, reset 0).
  - In IDLE, the latched address is checked against the mapped windows: 0x0000–0x2FFF, 0x7F00–0x7F0B, 0x7F20–0x7F3B, 0x7F40–0x7F47, 0x7F50–0x7F57, 0x7F58–0x7F5B, 0x7F60–0x7F63.
  - On a miss: PrWE is forced 0 for the whole transaction, rd_lat is forced 0, and the winner's err pulses together with its ack in DATA. Timing is unchanged.
- Undefined: no err ports, no address check; every access is passed to the bridge.

Test Plan:
- W=0; m0 reads 0x0000_1000 with PrRD=0xDEAD_BEEF → PrAddr=0x1000 for 1 cycle, m0_ack 3 cycles after req, m0_rd=0xDEAD_BEEF, PrWE=0 throughout.
- W=3; m1 writes 0x12345678 to 0x7F04 → PrWE=1 only in the first of 4 ADDR cycles, m1_ack 6 cycles after req, m0_ack stays 0.
- Both req from reset, held 4 transactions → grant order m0, m1, m0, m1; owner toggles each grant; no overlap of acks.
- reset asserted mid-ADDR of an m0 write, W=3 → outputs 0 immediately, no PrWE pulse, state IDLE; after release, m0 re-request completes normally.
- ARB_ERR_EN defined; m0 writes 0x0000_4000 → PrWE stays 0, m0_ack with m0_err=1 and m0_rd=0. Same access with the macro undefined → PrWE=1 for one cycle, no err port.
